npu_ahb_master: RTL

AHB-Lite initiator that drives the NPU's AHB slave port (CSRs at region 01, image memories mem0/mem1 at regions 10/11 of haddr[13:12]). It accepts single-word read/write commands from a local command port, buffers them in a small FIFO and issues them as non-pipelined SINGLE transfers. It returns one response per command. It sits between the host-side sequencer/bring-up logic and the NPU decoder.

---
 rtl/npu_ahb_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/npu_ahb_master.sv
// npu_ahb_master: AHB-Lite initiator issuing single-word NONSEQ transfers
// from a small command FIFO. Optional hready timeout: NPU_AHB_MST_TIMEOUT_EN.
module npu_ahb_master #(
    parameter int CMD_FIFO_DEPTH = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] ahb_m0_haddr_o,
    output logic        ahb_m0_hwrite_o,
    output logic [2:0]  ahb_m0_hsize_o,
    output logic [2:0]  ahb_m0_hburst_o,
    output logic [3:0]  ahb_m0_hprot_o,
    output logic [1:0]  ahb_m0_htrans_o,
    output logic        ahb_m0_hmastlock_o,
    output logic [31:0] ahb_m0_hwdata_o,
    input  logic        ahb_m0_hready_i,
    input  logic        ahb_m0_hresp_i,
    input  logic [31:0] ahb_m0_hrdata_i
);
    localparam int AW = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(CMD_FIFO_DEPTH);
    localparam logic [1:0] HT_IDLE = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t        r_state;
    logic [64:0]   r_mem [CMD_FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_haddr;
    logic          r_hwrite;
    logic [1:0]    r_htrans;
    logic [31:0]   r_hwdata;
    logic [31:0]   r_wdata;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;
    logic          w_push;
    logic          w_pop;
    logic [64:0]   w_head;
    logic          w_busy;
    logic          w_abort;

    assign cmd_ready = (r_count != FULL);
    assign w_push = cmd_valid & cmd_ready;
    assign w_pop = (r_state == S_IDLE) && (r_count != '0);
    assign w_head = r_mem[r_rptr];
    assign w_busy = (r_state == S_ADDR) || (r_state == S_DATA);

    assign ahb_m0_haddr_o = r_haddr;
    assign ahb_m0_hwrite_o = r_hwrite;
    assign ahb_m0_hsize_o = 3'b010;
    assign ahb_m0_hburst_o = 3'b000;
    assign ahb_m0_hprot_o = 4'b0011;
    assign ahb_m0_htrans_o = r_htrans;
    assign ahb_m0_hmastlock_o = 1'b0;
    assign ahb_m0_hwdata_o = r_hwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err = r_rsp_err;

`ifdef NPU_AHB_MST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_rsp_timeout;

    assign w_abort = w_busy & ~ahb_m0_hready_i
                   & (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout = r_rsp_timeout;

    // Count consecutive wait cycles of the current bus phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tcnt <= '0;
        else if (w_busy && !ahb_m0_hready_i)
            r_tcnt <= r_tcnt + 1'b1;
        else
            r_tcnt <= '0;
    end

    // Timeout flag: set by an abort, cleared by a normal completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rsp_timeout <= 1'b0;
        else if (w_abort)
            r_rsp_timeout <= 1'b1;
        else if (r_state == S_DATA && ahb_m0_hready_i)
            r_rsp_timeout <= 1'b0;
    end
`else
    assign w_abort = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // Command storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Transfer FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_haddr <= '0;
            r_hwrite <= 1'b0;
            r_htrans <= HT_IDLE;
            r_hwdata <= '0;
            r_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_hwrite <= w_head[64];
                        r_haddr <= w_head[63:32];
                        r_wdata <= w_head[31:0];
                        r_htrans <= HT_NONSEQ;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ahb_m0_hready_i) begin
                        r_htrans <= HT_IDLE;
                        r_hwdata <= r_hwrite ? r_wdata : 32'h0;
                        r_state <= S_DATA;
                    end else if (w_abort) begin
                        r_htrans <= HT_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_DATA: begin
                    if (ahb_m0_hready_i) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_hwrite ? 32'h0 : ahb_m0_hrdata_i;
                        r_rsp_err <= ahb_m0_hresp_i;
                        r_state <= S_RESP;
                    end else if (w_abort) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
